// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: sizing helpers, FSM encoding, reset coefficients.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    int unsigned v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v >>= 1;
    end
    return r;
  endfunction

  // Wide enough that TAPS full-scale products never overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic int unsigned default_coef(input int unsigned k, input int unsigned coef_w);
    return (k < coef_w && k < 32) ? (32'd1 << k) : 32'd0;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared multiply-accumulate unit; sum_c is the accumulator value after the current product.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [COEF_W-1:0] coef_i,
  output logic [ACC_W-1:0]  sum_c
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  acc_q;

  assign prod_c = PROD_W'(sample_i) * PROD_W'(coef_i);
  assign sum_c  = acc_q + ACC_W'(prod_c);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_c;
    end
  end

endmodule

// File: rtl/fir_tdm.sv
// Time-multiplexed FIR: one sample in, TAPS MAC cycles, scaled and saturated result held until taken.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned SHIFT  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     busy
);

  localparam int unsigned AW    = clog2(TAPS);
  localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] dline_q [TAPS];
  logic [DATA_W-1:0] dline_d [TAPS];
  logic [COEF_W-1:0] coef_q  [TAPS];
  logic [COEF_W-1:0] coef_d  [TAPS];
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic              in_ready_q, busy_q;
  logic              mac_clr, mac_en;
  logic [ACC_W-1:0]  sum_c, scaled_c;
  logic              clip_c;

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (mac_clr),
    .en_i     (mac_en),
    .sample_i (dline_q[idx_q]),
    .coef_i   (coef_q[idx_q]),
    .sum_c    (sum_c)
  );

  // Anything above the representable range clips to all ones.
  assign scaled_c = sum_c >> SHIFT;
  assign clip_c   = (scaled_c >> OUT_W) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dline_d     = dline_q;
    coef_d      = coef_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coef_we && (32'(coef_addr) < TAPS)) begin
          coef_d[coef_addr] = coef_wdata;
        end
        if (in_valid) begin
          dline_d[0] = in_data;
          for (int unsigned k = 1; k < TAPS; k++) begin
            dline_d[k] = dline_q[k-1];
          end
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        idx_d  = idx_q + AW'(1);
        if (32'(idx_q) == TAPS - 1) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = clip_c ? '1 : OUT_W'(scaled_c);
          out_sat_d   = clip_c;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        dline_q[k] <= '0;
        coef_q[k]  <= COEF_W'(default_coef(k, COEF_W));
      end
    end else begin
      idx_q       <= idx_d;
      dline_q     <= dline_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
